// File: rtl/axi_scale_complex_pkg.sv
// Shared constants for the axi_scale_complex gain stage: output width rule,
// reset gain value and the pipeline stage indices.
package axi_scale_complex_pkg;

  localparam int STAGE_S1   = 0;
  localparam int STAGE_S2   = 1;
  localparam int STAGE_S3   = 2;
  localparam int NUM_STAGES = 3;

  // One extra bit over the product width so that (-2^(W-1))^2 + (-2^(W-1))^2 fits.
  function automatic int width_out(input int width_in, input int width_coef);
    return width_in + width_coef + 1;
  endfunction

  // Largest positive coefficient, i.e. unity gain in Q(WIDTH_COEF-1) format.
  function automatic longint reset_gain_i(input int width_coef);
    return (longint'(1) <<< (width_coef - 1)) - 1;
  endfunction

endpackage

// File: rtl/axi_scale_complex_cmult.sv
// cmult_core: S2 products and S3 add/subtract of the complex gain, plus the
// valid/tlast shift for all three stages, all advancing on a shared enable.
module cmult_core
  import axi_scale_complex_pkg::*;
#(
  parameter int WIDTH_IN   = 16,
  parameter int WIDTH_COEF = 16,
  parameter int WIDTH_OUT  = 33
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  in_valid,
  input  logic                  in_last,
  input  logic [WIDTH_IN-1:0]   a_i,
  input  logic [WIDTH_IN-1:0]   a_q,
  input  logic [WIDTH_COEF-1:0] g_i,
  input  logic [WIDTH_COEF-1:0] g_q,
  output logic                  out_valid,
  output logic                  out_last,
  output logic [WIDTH_OUT-1:0]  out_i,
  output logic [WIDTH_OUT-1:0]  out_q
);

  localparam int WIDTH_PROD = WIDTH_IN + WIDTH_COEF;

  logic [NUM_STAGES-1:0]        valid_sr;
  logic [NUM_STAGES-1:0]        last_sr;
  logic signed [WIDTH_PROD-1:0] p_ii;
  logic signed [WIDTH_PROD-1:0] p_qq;
  logic signed [WIDTH_PROD-1:0] p_iq;
  logic signed [WIDTH_PROD-1:0] p_qi;

  // NOTE: every stage register uses <= so each stage samples its neighbour's
  // value from before the edge; blocking here would collapse the pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_sr <= '0;
      last_sr  <= '0;
    end else if (en) begin
      valid_sr[STAGE_S1] <= in_valid;
      valid_sr[STAGE_S2] <= valid_sr[STAGE_S1];
      valid_sr[STAGE_S3] <= valid_sr[STAGE_S2];
      last_sr[STAGE_S1]  <= in_last;
      last_sr[STAGE_S2]  <= last_sr[STAGE_S1];
      last_sr[STAGE_S3]  <= last_sr[STAGE_S2];
    end
  end

  // Operands are sign-extended to the product width first, so each product is exact.
  always_ff @(posedge clk) begin
    if (en) begin
      p_ii <= WIDTH_PROD'($signed(a_i)) * WIDTH_PROD'($signed(g_i));
      p_qq <= WIDTH_PROD'($signed(a_q)) * WIDTH_PROD'($signed(g_q));
      p_iq <= WIDTH_PROD'($signed(a_i)) * WIDTH_PROD'($signed(g_q));
      p_qi <= WIDTH_PROD'($signed(a_q)) * WIDTH_PROD'($signed(g_i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_i <= '0;
      out_q <= '0;
    end else if (en) begin
      out_i <= WIDTH_OUT'(p_ii) - WIDTH_OUT'(p_qq);
      out_q <= WIDTH_OUT'(p_iq) + WIDTH_OUT'(p_qi);
    end
  end

  assign out_valid = valid_sr[STAGE_S3];
  assign out_last  = last_sr[STAGE_S3];

endmodule

// File: rtl/axi_scale_complex.sv
// axi_scale_complex: AXI-Stream IQ samples times a runtime complex gain, full precision.
// Define AXI_SCALE_COMPLEX_SYNC_GAIN_EN to apply gain writes only at packet starts.
module axi_scale_complex
  import axi_scale_complex_pkg::*;
#(
  parameter int  WIDTH_IN   = 16,
  parameter int  WIDTH_COEF = 16,
  localparam int WIDTH_OUT  = width_out(WIDTH_IN, WIDTH_COEF)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    set_stb,
  input  logic [2*WIDTH_COEF-1:0] set_data,
  input  logic [2*WIDTH_IN-1:0]   i_tdata,
  input  logic                    i_tlast,
  input  logic                    i_tvalid,
  output logic                    i_tready,
  output logic [2*WIDTH_OUT-1:0]  o_tdata,
  output logic                    o_tlast,
  output logic                    o_tvalid,
  input  logic                    o_tready
);

  localparam logic [2*WIDTH_COEF-1:0] RESET_GAIN =
    {WIDTH_COEF'(reset_gain_i(WIDTH_COEF)), {WIDTH_COEF{1'b0}}};

  logic                    en;
  logic                    accept;
  logic [2*WIDTH_COEF-1:0] gain;
  logic [2*WIDTH_COEF-1:0] gain_sel;
  logic [2*WIDTH_IN-1:0]   s1_a;
  logic [2*WIDTH_COEF-1:0] s1_g;
  logic [WIDTH_OUT-1:0]    out_i;
  logic [WIDTH_OUT-1:0]    out_q;

  // The whole pipeline moves as one; a stalled output freezes every stage.
  assign en       = o_tready | ~o_tvalid;
  assign i_tready = en;
  assign accept   = i_tvalid & en;

`ifdef AXI_SCALE_COMPLEX_SYNC_GAIN_EN
  logic [2*WIDTH_COEF-1:0] pending;
  logic                    first;

  // A packet's first beat takes the pending gain directly, so it sees the same
  // value that the active register adopts on that edge.
  assign gain_sel = first ? pending : gain;

  always_ff @(posedge clk) begin
    if (reset) begin
      gain    <= RESET_GAIN;
      pending <= RESET_GAIN;
      first   <= 1'b1;
    end else begin
      if (set_stb) pending <= set_data;
      if (accept) begin
        first <= i_tlast;
        if (first) gain <= pending;
      end
    end
  end
`else
  assign gain_sel = gain;

  always_ff @(posedge clk) begin
    if (reset) begin
      gain <= RESET_GAIN;
    end else if (set_stb) begin
      gain <= set_data;
    end
  end
`endif

  // NOTE: S1 data registers have no reset; bubbles may carry stale data, and
  // the valid shift in cmult_core is what marks a beat as real.
  always_ff @(posedge clk) begin
    if (en) begin
      s1_a <= i_tdata;
      s1_g <= gain_sel;
    end
  end

  cmult_core #(
    .WIDTH_IN   (WIDTH_IN),
    .WIDTH_COEF (WIDTH_COEF),
    .WIDTH_OUT  (WIDTH_OUT)
  ) u_cmult (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .in_valid  (accept),
    .in_last   (i_tlast),
    .a_i       (s1_a[2*WIDTH_IN-1:WIDTH_IN]),
    .a_q       (s1_a[WIDTH_IN-1:0]),
    .g_i       (s1_g[2*WIDTH_COEF-1:WIDTH_COEF]),
    .g_q       (s1_g[WIDTH_COEF-1:0]),
    .out_valid (o_tvalid),
    .out_last  (o_tlast),
    .out_i     (out_i),
    .out_q     (out_q)
  );

  assign o_tdata = {out_i, out_q};

endmodule

// File: tb/tb_axi_scale_complex.sv
// Self-checking bench for axi_scale_complex (16/16 widths): a behavioural
// queue model of the gain rules plus directed literal checks.
module tb_axi_scale_complex;

  localparam int          WO         = 33;
  localparam logic [31:0] RESET_GAIN = 32'h7FFF_0000;
`ifdef AXI_SCALE_COMPLEX_SYNC_GAIN_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        set_stb = 1'b0;
  logic [31:0] set_data = '0;
  logic [31:0] i_tdata = '0;
  logic        i_tlast = 1'b0;
  logic        i_tvalid = 1'b0;
  logic        i_tready;
  logic [65:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready = 1'b1;
  logic        rand_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [65:0] data;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] m_gain;
  logic [31:0] m_pend;
  logic        m_first;
  logic        prev_stall;
  logic [66:0] prev_out;

  axi_scale_complex #(
    .WIDTH_IN   (16),
    .WIDTH_COEF (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .set_stb  (set_stb),
    .set_data (set_data),
    .i_tdata  (i_tdata),
    .i_tlast  (i_tlast),
    .i_tvalid (i_tvalid),
    .i_tready (i_tready),
    .o_tdata  (o_tdata),
    .o_tlast  (o_tlast),
    .o_tvalid (o_tvalid),
    .o_tready (o_tready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Exact complex product using 64-bit integer arithmetic.
  function automatic logic [65:0] model_mult(input logic [31:0] a, input logic [31:0] g);
    longint ai, aq, gi, gq, ri, rq;
    ai = longint'($signed(a[31:16]));
    aq = longint'($signed(a[15:0]));
    gi = longint'($signed(g[31:16]));
    gq = longint'($signed(g[15:0]));
    ri = ai * gi - aq * gq;
    rq = ai * gq + aq * gi;
    return {ri[WO-1:0], rq[WO-1:0]};
  endfunction

  // Model + compare: at each falling edge, judge what the next rising edge will do.
  always @(negedge clk) begin
    logic        en_exp;
    logic [31:0] g;
    beat_t       b;
    if (reset) begin
      exp_q.delete();
      m_gain     = RESET_GAIN;
      m_pend     = RESET_GAIN;
      m_first    = 1'b1;
      prev_stall = 1'b0;
    end else begin
      en_exp = o_tready || !o_tvalid;
      check("i_tready", {66'b0, i_tready}, {66'b0, en_exp});
      if (prev_stall) check("stall_hold", {o_tlast, o_tdata}, prev_out);
      if (exp_q.size() == 0) check("spurious_o_tvalid", {66'b0, o_tvalid}, 67'b0);
      if (o_tvalid && o_tready && exp_q.size() != 0) begin
        b = exp_q.pop_front();
        check("o_tdata", {1'b0, o_tdata}, {1'b0, b.data});
        check("o_tlast", {66'b0, o_tlast}, {66'b0, b.last});
      end
      prev_stall = o_tvalid && !o_tready;
      prev_out   = {o_tlast, o_tdata};
      if (i_tvalid && en_exp) begin
        g = (SYNC && m_first) ? m_pend : m_gain;
        exp_q.push_back(beat_t'{data: model_mult(i_tdata, g), last: i_tlast});
        if (SYNC && m_first) m_gain = m_pend;
        m_first = i_tlast;
      end
      if (set_stb) begin
        if (SYNC) m_pend = set_data;
        else      m_gain = set_data;
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (rand_ready) o_tready = 1'($urandom_range(0, 1));
  end

  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic set_gain(input logic [31:0] g);
    set_stb  = 1'b1;
    set_data = g;
    @(posedge clk); #1;
    set_stb  = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    bit ok;
    int guard;
    i_tvalid = 1'b1;
    i_tdata  = d;
    i_tlast  = last;
    guard    = 0;
    do begin
      @(negedge clk);
      ok = i_tready;
      @(posedge clk); #1;
      guard++;
    end while (!ok && guard < 100);
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_accept actual=not_accepted required=accepted");
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!o_tvalid && lat < 20);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || o_tvalid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 67'(exp_q.size()), 67'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    repeat (2) @(posedge clk);
    #1;
    check("reset_o_tvalid", {66'b0, o_tvalid}, 67'b0);
    check("reset_o_tlast", {66'b0, o_tlast}, 67'b0);
    check("reset_o_tdata", {1'b0, o_tdata}, 67'b0);
    reset = 1'b0;

    // Model pins against hand-computed values.
    check("pin_model_basic", {1'b0, model_mult(32'h1000_F000, 32'h4000_0000)},
          {1'b0, 33'h0_0400_0000, 33'h1_FC00_0000});
    check("pin_model_corner", {1'b0, model_mult(32'h8000_8000, 32'h8000_8000)},
          {1'b0, 33'h0_0000_0000, 33'h0_8000_0000});

    // Basic gain and latency.
    set_gain(32'h4000_0000);
    send(32'h1000_F000, 1'b1);
    i_tvalid = 1'b0;
    wait_valid(lat);
    check("latency_basic", 67'(lat), 67'd3);
    check("basic_o_tdata", {1'b0, o_tdata}, {1'b0, 33'h0_0400_0000, 33'h1_FC00_0000});
    @(posedge clk); #1;

    // Most-negative corner: Q = +2^31 must not wrap.
    set_gain(32'h8000_8000);
    send(32'h8000_8000, 1'b1);
    i_tvalid = 1'b0;
    wait_valid(lat);
    check("latency_corner", 67'(lat), 67'd3);
    check("corner_o_tdata", {1'b0, o_tdata}, {1'b0, 33'h0_0000_0000, 33'h0_8000_0000});
    check("corner_o_tlast", {66'b0, o_tlast}, 67'd1);
    @(posedge clk); #1;

    // Gain write in the same cycle a mid-packet beat is accepted.
    set_gain(32'h4000_0000);
    send(32'h0100_0200, 1'b0);
    set_stb  = 1'b1;
    set_data = 32'h0000_2000;
    send(32'h0300_0400, 1'b0);
    set_stb  = 1'b0;
    send(32'h0500_0600, 1'b0);
    send(32'h0700_0800, 1'b1);
    // Next packet: a sync build picks up the new gain here.
    send(32'h0900_0A00, 1'b0);
    send(32'hF700_0B00, 1'b1);
    i_tvalid = 1'b0;
    drain();

    // Gain write coinciding with the first beat of a packet.
    set_stb  = 1'b1;
    set_data = 32'h1234_F00D;
    send(32'h0011_0022, 1'b0);
    set_stb  = 1'b0;
    send(32'h0033_0044, 1'b1);
    send(32'hFF55_0066, 1'b1);
    i_tvalid = 1'b0;
    drain();

    // Random backpressure, 20 beats, occasional input gaps.
    rand_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 7) set_stb = 1'b1;
      set_data = 32'h2000_E000;
      send($urandom(), 1'((i % 5) == 4));
      set_stb = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        i_tvalid = 1'b0;
        @(posedge clk); #1;
      end
    end
    i_tvalid   = 1'b0;
    rand_ready = 1'b0;
    o_tready   = 1'b1;
    drain();

    // Reset with two beats in flight and a beat presented during reset.
    send(32'h1111_2222, 1'b0);
    send(32'h3333_4444, 1'b0);
    i_tdata  = 32'h5555_6666;
    i_tvalid = 1'b1;
    reset    = 1'b1;
    @(posedge clk); #1;
    reset    = 1'b0;
    i_tvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_reset_o_tvalid", {66'b0, o_tvalid}, 67'b0);
    end
    @(posedge clk); #1;
    send(32'h0100_0200, 1'b1);
    i_tvalid = 1'b0;
    wait_valid(lat);
    check("latency_post_reset", 67'(lat), 67'd3);
    check("post_reset_gain", {1'b0, o_tdata}, {1'b0, 33'h0_007F_FF00, 33'h0_00FF_FE00});
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog timeout");
  end

endmodule
